// File: rtl/fifo_rd_32_to_128.sv
// fifo_rd_32_to_128: pops four 32-bit FIFO words and assembles them MSW-first into a 128-bit block.
// Build option FIFO_RD_BYTE_SWAP_EN byte-reverses each captured word before it is stored.
`default_nettype none

module fifo_rd_32_to_128 #(
  parameter int I_W_WIDTH = 32,
  parameter int O_W_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [I_W_WIDTH-1:0] idata,
  input  logic                 not_empty,
  input  logic                 i_pull,
  output logic                 o_pop,
  output logic [O_W_WIDTH-1:0] odata,
  output logic                 rdy
);

  localparam int SLOTS = O_W_WIDTH / I_W_WIDTH;
  localparam logic [O_W_WIDTH-1:0] LOW_MASK =
    {{(O_W_WIDTH-I_W_WIDTH){1'b0}}, {I_W_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    POP  = 2'd0,
    PEND = 2'd1,
    CAPT = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [1:0]             cnt, cnt_n;
  logic                   pop_n, rdy_n;
  logic [O_W_WIDTH-1:0]   odata_n;
  logic [I_W_WIDTH-1:0]   word;
  logic [7:0]             shamt;

`ifdef FIFO_RD_BYTE_SWAP_EN
  always_comb begin
    word = '0;
    for (int b = 0; b < I_W_WIDTH/8; b++) begin
      word[8*b +: 8] = idata[I_W_WIDTH-8-8*b +: 8];
    end
  end
`else
  always_comb begin
    word = idata;
  end
`endif

  // slot 0 is the most significant word, so the shift shrinks as cnt grows
  always_comb begin
    shamt = 8'((SLOTS - 1 - int'(cnt)) * I_W_WIDTH);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop_n   = 1'b0;
    rdy_n   = rdy;
    odata_n = odata;
    case (state)
      POP: begin
        if (not_empty) begin
          pop_n   = 1'b1;
          state_n = PEND;
        end
      end
      PEND: begin
        state_n = CAPT;
      end
      CAPT: begin
        odata_n = (odata & ~(LOW_MASK << shamt)) |
                  ({{(O_W_WIDTH-I_W_WIDTH){1'b0}}, word} << shamt);
        if (cnt == 2'(SLOTS - 1)) begin
          cnt_n   = 2'd0;
          rdy_n   = 1'b1;
          state_n = FULL;
        end else begin
          cnt_n   = cnt + 2'd1;
          state_n = POP;
        end
      end
      FULL: begin
        if (i_pull) begin
          rdy_n   = 1'b0;
          state_n = POP;
        end
      end
      default: state_n = POP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= POP;
      cnt   <= 2'd0;
      o_pop <= 1'b0;
      rdy   <= 1'b0;
      odata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      o_pop <= pop_n;
      rdy   <= rdy_n;
      odata <= odata_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_32_to_128.sv
// tb_fifo_rd_32_to_128: directed table-driven bench with a FIFO model feeding idata after each pop.
`default_nettype none

module tb_fifo_rd_32_to_128;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  idata;
  logic         not_empty;
  logic         i_pull;
  logic         o_pop;
  logic [127:0] odata;
  logic         rdy;

  always #5 clk = ~clk;

  fifo_rd_32_to_128 #(.I_W_WIDTH(32), .O_W_WIDTH(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .idata     (idata),
    .not_empty (not_empty),
    .i_pull    (i_pull),
    .o_pop     (o_pop),
    .odata     (odata),
    .rdy       (rdy)
  );

  typedef struct {
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] exp_plain;
    logic [127:0] exp_swap;
  } vec_t;

  vec_t        tbl [4];
  int          errors = 0;
  int          checks = 0;
  int          pops;
  logic        prev_pop;
  logic        gate;
  logic [31:0] fifo_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_of(input vec_t v);
`ifdef FIFO_RD_BYTE_SWAP_EN
    return v.exp_swap;
`else
    return v.exp_plain;
`endif
  endfunction

  task automatic update_ne();
    not_empty = gate && (fifo_q.size() > 0);
  endtask

  // one clock; the FIFO model answers a pop with data valid the following cycle
  task automatic step();
    @(negedge clk);
    if (o_pop === 1'b1) begin
      pops++;
      check("pop_not_back_to_back", {127'd0, prev_pop}, 128'd0);
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underflow: got pop with empty FIFO, expected no pop");
      end else begin
        idata = fifo_q.pop_front();
      end
    end
    prev_pop = o_pop;
    update_ne();
  endtask

  task automatic load(input vec_t v);
    fifo_q.push_back(v.w0);
    fifo_q.push_back(v.w1);
    fifo_q.push_back(v.w2);
    fifo_q.push_back(v.w3);
    update_ne();
  endtask

  task automatic wait_rdy(input string name, input logic [127:0] exp);
    int n = 0;
    while (rdy !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check({name, "_rdy"}, {127'd0, rdy}, 128'd1);
    check({name, "_odata"}, odata, exp);
    check({name, "_pops"}, 128'(pops), 128'd4);
  endtask

  task automatic wait_pops(input string name, input int target);
    int n = 0;
    while (pops < target && n < 40) begin
      step();
      n++;
    end
    check({name, "_pop_wait"}, 128'(pops), 128'(target));
  endtask

  task automatic pull(input string name);
    i_pull = 1'b1;
    step();
    i_pull = 1'b0;
    check({name, "_rdy_after_pull"}, {127'd0, rdy}, 128'd0);
  endtask

  initial begin
    logic [11:0]  pop_pat;
    logic [127:0] held;

    tbl[0] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
               128'h00112233445566778899AABBCCDDEEFF,
               128'h3322110077665544BBAA9988FFEEDDCC};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
               128'hFFFFFFFF00000000FFFFFFFF00000000,
               128'hFFFFFFFF00000000FFFFFFFF00000000};
    tbl[2] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hDEADBEEF,
               128'h123456789ABCDEF00F0F0F0FDEADBEEF,
               128'h78563412F0DEBC9A0F0F0F0FEFBEADDE};
    tbl[3] = '{32'h00000001, 32'h80000000, 32'hA5A5A5A5, 32'h5A5A5A5A,
               128'h0000000180000000A5A5A5A55A5A5A5A,
               128'h0100000000000080A5A5A5A55A5A5A5A};

    reset = 1'b1; i_pull = 1'b0; idata = '0; gate = 1'b0;
    not_empty = 1'b0; pops = 0; prev_pop = 1'b0;
    step(); step();
    check("reset_o_pop", {127'd0, o_pop}, 128'd0);
    check("reset_rdy", {127'd0, rdy}, 128'd0);
    check("reset_odata", odata, 128'd0);

    // first block: pop cadence and 12-cycle latency from reset release
    gate = 1'b1;
    load(tbl[0]);
    @(negedge clk);
    reset = 1'b0;
    pop_pat = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      pop_pat[i-1] = o_pop;
      if (i == 11) check("latency_rdy_low_c11", {127'd0, rdy}, 128'd0);
      if (i == 12) check("latency_rdy_high_c12", {127'd0, rdy}, 128'd1);
    end
    check("pop_pattern", 128'(pop_pat), 128'h249);
    check("blk0_odata", odata, exp_of(tbl[0]));
    check("blk0_pops", 128'(pops), 128'd4);
    pull("blk0");

    for (int k = 1; k < 4; k++) begin
      pops = 0;
      load(tbl[k]);
      wait_rdy($sformatf("tbl%0d", k), exp_of(tbl[k]));
      pull($sformatf("tbl%0d", k));
    end

    // starvation gap after the second word, with a stray pull while not ready
    pops = 0;
    load(tbl[1]);
    wait_pops("gap", 2);
    gate = 1'b0;
    update_ne();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) i_pull = 1'b1;
      step();
      i_pull = 1'b0;
    end
    check("gap_no_pops", 128'(pops), 128'd2);
    check("gap_rdy_low", {127'd0, rdy}, 128'd0);
    gate = 1'b1;
    update_ne();
    wait_rdy("gap", exp_of(tbl[1]));

    // hold in FULL with words waiting, then a single-cycle pull
    load(tbl[2]);
    held = odata;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_odata", odata, exp_of(tbl[1]));
    end
    check("hold_no_pops", 128'(pops), 128'd0);
    check("hold_rdy", {127'd0, rdy}, 128'd1);
    i_pull = 1'b1;
    step();
    i_pull = 1'b0;
    check("pull_rdy_next", {127'd0, rdy}, 128'd0);
    check("pull_no_pop_next", {127'd0, o_pop}, 128'd0);
    step();
    check("pull_pop_2cyc", {127'd0, o_pop}, 128'd1);
    wait_rdy("after_hold", exp_of(tbl[2]));
    check("held_was_prev", held, exp_of(tbl[1]));
    pull("after_hold");

    // reset while capturing the third word (CAPT, cnt=2)
    pops = 0;
    load(tbl[3]);
    wait_pops("midrst", 3);
    step();
    #2 reset = 1'b1;
    #1;
    check("midrst_o_pop", {127'd0, o_pop}, 128'd0);
    check("midrst_rdy", {127'd0, rdy}, 128'd0);
    check("midrst_odata", odata, 128'd0);
    fifo_q.delete();
    step();
    load(tbl[0]);
    @(negedge clk);
    reset = 1'b0;
    pops = 0;
    prev_pop = 1'b0;
    wait_rdy("fresh", exp_of(tbl[0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_32_to_128.md
FIFO_RD_32_TO_128 -- requirements
Module: fifo_rd_32_to_128

Interface
REQ-001 The block SHALL have parameter I_W_WIDTH, default 32, meaning FIFO read word width.
REQ-002 The block SHALL have parameter O_W_WIDTH, default 128, meaning assembled output block width; only 32/128 is supported.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port idata  input  I_W_WIDTH  FIFO read data, valid the cycle after o_pop is high.
REQ-006 Port not_empty  input  1  FIFO holds at least one word.
REQ-007 Port i_pull  input  1  consumer takes odata; sampled only while rdy=1.
REQ-008 Port o_pop  output  1  FIFO pop strobe, registered, one cycle wide.
REQ-009 Port odata  output  O_W_WIDTH  assembled 128-bit block, registered.
REQ-010 Port rdy  output  1  odata holds a complete block, registered.

Function
REQ-011 The FSM SHALL have exactly four states: POP, PEND, CAPT and FULL, plus a 2-bit word counter cnt.
REQ-012 In POP with not_empty=1, the block SHALL drive o_pop=1 on the next cycle and enter PEND.
REQ-013 In POP with not_empty=0, the block SHALL hold state, keep o_pop=0 and keep cnt unchanged.
REQ-014 In PEND, the block SHALL drive o_pop=0 and enter CAPT unconditionally.
REQ-015 In CAPT, the block SHALL write idata into odata slot cnt, where cnt=0 selects [127:96], 1 selects [95:64], 2 selects [63:32] and 3 selects [31:0].
REQ-016 In CAPT with cnt<3, the block SHALL increment cnt and enter POP.
REQ-017 In CAPT with cnt=3, the block SHALL set rdy=1 on the next cycle, clear cnt and enter FULL.
REQ-018 o_pop SHALL never be high on two consecutive cycles, and the block SHALL issue at most 4 pops per block.
REQ-019 Minimum latency SHALL be 12 cycles from the first POP cycle with not_empty=1 to rdy=1, given not_empty held high.
REQ-020 In FULL, the block SHALL issue no pops, and odata and rdy SHALL hold steady until i_pull.
REQ-021 In FULL with i_pull=1, the block SHALL drive rdy=0 on the next cycle and enter POP.
REQ-022 i_pull while rdy=0 SHALL be ignored.
REQ-023 After a pull, odata contents SHALL be undefined to the consumer until rdy rises again; each slot is overwritten as it is captured.
REQ-024 not_empty dropping in PEND or CAPT SHALL NOT abort the capture in flight.

Reset
REQ-025 While reset=1, the block SHALL set state to POP, cnt=0, o_pop=0, rdy=0 and odata=0, asynchronously.
REQ-026 A reset mid-block SHALL discard the partially assembled block, and any FIFO word already popped SHALL be lost without recovery.
REQ-027 On the first cycle after reset release, the block SHALL evaluate not_empty in POP.

Configuration
REQ-028 With macro FIFO_RD_BYTE_SWAP_EN defined, each captured 32-bit word SHALL be byte-reversed before storage, so that idata[7:0] lands in the slot's most significant byte.
REQ-029 Without FIFO_RD_BYTE_SWAP_EN, words SHALL be stored unmodified.
REQ-030 No other behaviour or timing SHALL differ between the two builds.

Verification
REQ-031 Bench SHALL cover this case: reset release, not_empty=1, FIFO words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> exactly 4 single-cycle o_pop pulses spaced 3 cycles apart, rdy=1 12 cycles after the first POP cycle, odata=0x00112233445566778899AABBCCDDEEFF.
REQ-032 Bench SHALL cover this case: not_empty held low after the second word for 10 cycles -> no o_pop during the gap, then the block resumes and the final odata is correct.
REQ-033 Bench SHALL cover this case: rdy=1 with i_pull held low for 20 cycles -> odata stable and no o_pop; then i_pull=1 for one cycle -> rdy=0 next cycle and the next o_pop 2 cycles after the pull.
REQ-034 Bench SHALL cover this case: reset asserted in CAPT with cnt=2 -> all outputs 0 immediately; the next block assembles from fresh words only.
REQ-035 Bench SHALL cover this case: FIFO_RD_BYTE_SWAP_EN defined, word 0x00112233 captured into slot 0 -> odata[127:96]=0x33221100.
REQ-036 Bench SHALL cover this case: i_pull pulsed while rdy=0 during fill -> no effect on state, cnt or odata.
